// File: rtl/dift_trap_ctrl.sv
// DIFT trap controller: turns tag-check trap pulses into a held exception request
// (req/ack), keeps sticky cause/PC/overflow status, optional counters via DIFT_TRAP_COUNTERS_EN.
module dift_trap_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int TYPE_WIDTH = 3,
  parameter int NUM_TYPES  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trap_i,
  input  logic [TYPE_WIDTH-1:0] trap_type_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic                  flush_i,
  output logic                  exc_req_o,
  input  logic                  exc_ack_i,
  input  logic                  handler_done_i,
  output logic [TYPE_WIDTH-1:0] exc_type_o,
  output logic [PC_WIDTH-1:0]   exc_pc_o,
  output logic                  overflow_o,
  output logic                  busy_o,
  input  logic                  csr_clear_i,
  input  logic [TYPE_WIDTH-1:0] cnt_sel_i,
  output logic [CNT_WIDTH-1:0]  cnt_o
);

  // Handshake: exc_req_o stays high from the cycle after capture until the cycle
  // exc_ack_i is sampled high; it drops on the following cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TYPE_WIDTH-1:0] type_q, type_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  ovf_q, ovf_d;
  logic                  trap_acc;

  assign trap_acc = trap_i & ~flush_i;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (trap_acc) begin
          type_d  = trap_type_i;
          pc_d    = pc_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (exc_ack_i) state_d = SERV;
      end
      SERV: begin
        if (handler_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Any accepted trap outside IDLE is lost; setting beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (trap_acc && (state_q != IDLE)) ovf_d = 1'b1;
    else if (csr_clear_i)              ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign exc_req_o  = (state_q == REQ);
  assign busy_o     = (state_q != IDLE);
  assign exc_type_o = type_q;
  assign exc_pc_o   = pc_q;
  assign overflow_o = ovf_q;

`ifdef DIFT_TRAP_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_TYPES];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_TYPES];

  // Saturating per-type counters; a clear beats a same-cycle increment.
  always_comb begin
    for (int i = 0; i < NUM_TYPES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (csr_clear_i) begin
        cnt_d[i] = '0;
      end else if (trap_acc && (trap_type_i == TYPE_WIDTH'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TYPES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TYPES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if (cnt_sel_i == TYPE_WIDTH'(i)) cnt_o = cnt_q[i];
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel_i;
  assign cnt_o          = '0;
`endif

endmodule

// File: tb/tb_dift_trap_ctrl.sv
// Directed bench for dift_trap_ctrl: capture, handshake, flush, overflow, clear,
// out-of-range type, optional counters (DIFT_TRAP_COUNTERS_EN), async reset.
module tb_dift_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_i, flush_i, exc_ack_i, handler_done_i, csr_clear_i;
  logic [2:0]  trap_type_i, cnt_sel_i;
  logic [31:0] pc_i;
  logic        exc_req_o, overflow_o, busy_o;
  logic [2:0]  exc_type_o;
  logic [31:0] exc_pc_o;
  logic [15:0] cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dift_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .trap_i(trap_i), .trap_type_i(trap_type_i),
    .pc_i(pc_i), .flush_i(flush_i), .exc_req_o(exc_req_o), .exc_ack_i(exc_ack_i),
    .handler_done_i(handler_done_i), .exc_type_o(exc_type_o), .exc_pc_o(exc_pc_o),
    .overflow_o(overflow_o), .busy_o(busy_o), .csr_clear_i(csr_clear_i),
    .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_i = 1'b0; flush_i = 1'b0; exc_ack_i = 1'b0;
    handler_done_i = 1'b0; csr_clear_i = 1'b0;
  endtask

  task automatic trap(input logic [2:0] t, input logic [31:0] pc);
    trap_i = 1'b1; trap_type_i = t; pc_i = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    trap_type_i = '0; pc_i = '0; cnt_sel_i = '0;
    tick(); tick();
    check("rst_req",  exc_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_type", exc_type_o, 0);
    check("rst_pc",   exc_pc_o, 0);
    check("rst_ovf",  overflow_o, 0);
    check("rst_cnt",  cnt_o, 0);
    rst_n = 1'b1;
    tick();

    // Basic capture and handshake
    trap(3'd2, 32'h0000_1004); tick(); idle_inputs();
    check("t1_req",  exc_req_o, 1);
    check("t1_type", exc_type_o, 2);
    check("t1_pc",   exc_pc_o, 32'h1004);
    check("t1_busy", busy_o, 1);
    tick(); tick();
    check("t1_req_held", exc_req_o, 1);
    exc_ack_i = 1'b1; tick(); idle_inputs();
    check("t1_req_drop", exc_req_o, 0);
    check("t1_serv_busy", busy_o, 1);
    tick();
    check("t1_serv_hold", busy_o, 1);
    handler_done_i = 1'b1; tick(); idle_inputs();
    check("t1_done_busy", busy_o, 0);
    check("t1_done_pc",   exc_pc_o, 32'h1004);
    check("t1_done_ovf",  overflow_o, 0);

    // Flushed trap is dropped
    cnt_sel_i = 3'd1;
    trap(3'd1, 32'h0000_DEAD); flush_i = 1'b1; tick(); idle_inputs();
    check("fl_req",  exc_req_o, 0);
    check("fl_busy", busy_o, 0);
    check("fl_ovf",  overflow_o, 0);
    check("fl_pc",   exc_pc_o, 32'h1004);
    check("fl_cnt",  cnt_o, 0);

    // Ack and trap in the same cycle while in REQ
    trap(3'd0, 32'h0000_0100); tick(); idle_inputs();
    check("t3_req", exc_req_o, 1);
    trap(3'd4, 32'h0000_2000); exc_ack_i = 1'b1; tick(); idle_inputs();
    check("t3_req_drop", exc_req_o, 0);
    check("t3_busy", busy_o, 1);
    check("t3_pc",   exc_pc_o, 32'h0100);
    check("t3_type", exc_type_o, 0);
    check("t3_ovf",  overflow_o, 1);
    csr_clear_i = 1'b1; tick(); idle_inputs();
    check("t3_clr_ovf",  overflow_o, 0);
    check("t3_clr_busy", busy_o, 1);
    check("t3_clr_pc",   exc_pc_o, 32'h0100);
    trap(3'd1, 32'h0000_4000); csr_clear_i = 1'b1; tick(); idle_inputs();
    check("t3_set_wins", overflow_o, 1);
    exc_ack_i = 1'b1; tick(); idle_inputs();
    check("t3_ack_ign_busy", busy_o, 1);
    check("t3_ack_ign_req",  exc_req_o, 0);

    // Done and trap in the same cycle while in SERV
    trap(3'd1, 32'h0000_5000); handler_done_i = 1'b1; tick(); idle_inputs();
    check("t4_busy", busy_o, 0);
    check("t4_ovf",  overflow_o, 1);
    check("t4_pc",   exc_pc_o, 32'h0100);
    trap(3'd3, 32'h0000_3000); tick(); idle_inputs();
    check("t4_req",  exc_req_o, 1);
    check("t4_type", exc_type_o, 3);
    check("t4_pc2",  exc_pc_o, 32'h3000);
    handler_done_i = 1'b1; tick(); idle_inputs();
    check("t4_done_ign", exc_req_o, 1);
    exc_ack_i = 1'b1; tick(); idle_inputs();
    handler_done_i = 1'b1; csr_clear_i = 1'b1; tick(); idle_inputs();
    check("t4_idle", busy_o, 0);
    check("t4_clr",  overflow_o, 0);

    // Out-of-range type is captured verbatim
    trap(3'd7, 32'h0000_7000); tick(); idle_inputs();
    check("t5_type", exc_type_o, 7);
    check("t5_pc",   exc_pc_o, 32'h7000);
    exc_ack_i = 1'b1; tick(); idle_inputs();
    handler_done_i = 1'b1; tick(); idle_inputs();
    check("t5_idle", busy_o, 0);

`ifdef DIFT_TRAP_COUNTERS_EN
    cnt_sel_i = 3'd1;
    check("c_start", cnt_o, 0);
    trap(3'd1, 32'h0000_0010); tick();
    trap(3'd1, 32'h0000_0014); tick();
    trap(3'd1, 32'h0000_0018); tick(); idle_inputs();
    check("c_three", cnt_o, 3);
    check("c_ovf",   overflow_o, 1);
    cnt_sel_i = 3'd7;
    check("c_oor_sel", cnt_o, 0);
    cnt_sel_i = 3'd1;
    force dut.cnt_q[1] = 16'hFFFF;
    #1;
    release dut.cnt_q[1];
    trap(3'd1, 32'h0000_001C); tick(); idle_inputs();
    check("c_sat", cnt_o, 16'hFFFF);
    trap(3'd1, 32'h0000_0020); csr_clear_i = 1'b1; tick(); idle_inputs();
    check("c_clr_wins", cnt_o, 0);
    exc_ack_i = 1'b1; tick(); idle_inputs();
    handler_done_i = 1'b1; csr_clear_i = 1'b1; tick(); idle_inputs();
    check("c_idle", busy_o, 0);
`else
    trap(3'd1, 32'h0000_0010); tick(); idle_inputs();
    check("nc_cnt", cnt_o, 0);
    exc_ack_i = 1'b1; tick(); idle_inputs();
    handler_done_i = 1'b1; tick(); idle_inputs();
`endif

    // Asynchronous reset while in REQ
    trap(3'd2, 32'h0000_9000); tick(); idle_inputs();
    check("r_req_before", exc_req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_req_async",  exc_req_o, 0);
    check("r_busy_async", busy_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("r_req",  exc_req_o, 0);
    check("r_busy", busy_o, 0);
    check("r_type", exc_type_o, 0);
    check("r_pc",   exc_pc_o, 0);
    check("r_ovf",  overflow_o, 0);
    check("r_cnt",  cnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
